// File: rtl/dehaze_stream_framer.sv
// Dehaze stream framer: tags pixels from the dehaze core with frame
// position (sof/eol/eof), buffers them in a small FIFO and presents them
// as an AXI4-Stream master with a registered output stage.
// Optional macro FRAMER_LINE_TLAST_EN: when defined, m_axis_tlast marks
// every line end; otherwise it marks only the end of frame.
module dehaze_stream_framer #(
    parameter int IMG_WIDTH  = 512,
    parameter int IMG_HEIGHT = 512,
    parameter int FIFO_DEPTH = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
    input  logic [31:0] s_data,
    input  logic        s_valid,
    output logic [31:0] m_axis_tdata,
    output logic        m_axis_tvalid,
    input  logic        m_axis_tready,
    output logic        m_axis_tlast,
    output logic        m_axis_tuser,
    output logic        overflow,
    output logic        frame_done
);

    localparam int CW = (IMG_WIDTH > 1) ? $clog2(IMG_WIDTH) : 1;
    localparam int RW = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int EW = 35;
    localparam logic [CW-1:0] COL_LAST = CW'(IMG_WIDTH - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_HEIGHT - 1);
    localparam logic [AW:0]   CNT_FULL = (AW + 1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        ACTIVE,
        DRAIN
    } state_t;

    state_t        state;
    logic [CW-1:0] col;
    logic [RW-1:0] row;

    // Entry layout: {sof, eof, last, data}; "last" is the tlast tag chosen at push time
    logic [EW-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic [EW-1:0] head;

    logic          acc;
    logic          full;
    logic          pop;
    logic          push;
    logic          sof;
    logic          eol;
    logic          eof;
    logic          last_tag;
    logic [EW-1:0] push_word;
    logic [EW-1:0] next_word;

    // Handshake decode, position tags and the word to store
    always_comb begin
        acc       = s_valid & enable;
        full      = (count == CNT_FULL);
        pop       = m_axis_tvalid & m_axis_tready;
        push      = acc & (~full | pop);
        sof       = (col == '0) && (row == '0);
        eol       = (col == COL_LAST);
        eof       = eol && (row == ROW_LAST);
`ifdef FRAMER_LINE_TLAST_EN
        last_tag  = eol;
`else
        last_tag  = eof;
`endif
        push_word = {sof, eof, last_tag, s_data};
        next_word = mem[rd_ptr + 1'b1];
    end

    // Output fields come straight from the head register
    always_comb begin
        m_axis_tdata = head[31:0];
        m_axis_tlast = head[32];
        m_axis_tuser = head[34];
    end

    // Column/row position; advances on every accepted beat, stored or dropped
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            col <= '0;
            row <= '0;
        end else if (acc) begin
            if (eol) begin
                col <= '0;
                row <= (row == ROW_LAST) ? '0 : row + 1'b1;
            end else begin
                col <= col + 1'b1;
            end
        end
    end

    // Beat storage (no reset needed: validity is tracked by count)
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= push_word;
        end
    end

    // FIFO pointers and occupancy; occupancy includes the beat held in head
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Head register mirrors the oldest FIFO entry so the output is registered;
    // a push into an empty (or emptying) FIFO bypasses straight into it
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head          <= '0;
            m_axis_tvalid <= 1'b0;
        end else if (pop) begin
            if (count > (AW + 1)'(1)) begin
                head <= next_word;
            end else if (push) begin
                head <= push_word;
            end else begin
                m_axis_tvalid <= 1'b0;
            end
        end else if (count == '0 && push) begin
            head          <= push_word;
            m_axis_tvalid <= 1'b1;
        end
    end

    // Sticky overflow and end-of-frame transfer pulse
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overflow   <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            overflow   <= overflow | (acc & full & ~pop);
            frame_done <= pop & head[33];
        end
    end

    // Frame progress FSM
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (acc) state <= ACTIVE;
                end
                ACTIVE: begin
                    if (acc && eof) state <= DRAIN;
                end
                DRAIN: begin
                    if (acc) begin
                        state <= ACTIVE;
                    end else if (pop && head[33]) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dehaze_stream_framer.sv
// Testbench for dehaze_stream_framer: directed scenarios plus random traffic
// checked against a queue-based reference model.
module tb_dehaze_stream_framer;

    localparam int W = 4;
    localparam int H = 2;
    localparam int D = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        enable = 1'b0;
    logic [31:0] s_data = '0;
    logic        s_valid = 1'b0;
    logic [31:0] m_axis_tdata;
    logic        m_axis_tvalid;
    logic        m_axis_tready = 1'b0;
    logic        m_axis_tlast;
    logic        m_axis_tuser;
    logic        overflow;
    logic        frame_done;

    dehaze_stream_framer #(
        .IMG_WIDTH (W),
        .IMG_HEIGHT(H),
        .FIFO_DEPTH(D)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .enable       (enable),
        .s_data       (s_data),
        .s_valid      (s_valid),
        .m_axis_tdata (m_axis_tdata),
        .m_axis_tvalid(m_axis_tvalid),
        .m_axis_tready(m_axis_tready),
        .m_axis_tlast (m_axis_tlast),
        .m_axis_tuser (m_axis_tuser),
        .overflow     (overflow),
        .frame_done   (frame_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] data;
        bit          sof;
        bit          eol;
        bit          eof;
    } beat_t;

    beat_t q[$];
    int    idx;
    bit    exp_ovf;
    bit    exp_fd;
    int    checks = 0;
    int    errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic compare();
        bit exp_last;
        check("tvalid", {31'b0, m_axis_tvalid}, {31'b0, q.size() > 0});
        if (q.size() > 0) begin
`ifdef FRAMER_LINE_TLAST_EN
            exp_last = q[0].eol;
`else
            exp_last = q[0].eof;
`endif
            check("tdata", m_axis_tdata, q[0].data);
            check("tuser", {31'b0, m_axis_tuser}, {31'b0, q[0].sof});
            check("tlast", {31'b0, m_axis_tlast}, {31'b0, exp_last});
        end
        check("overflow", {31'b0, overflow}, {31'b0, exp_ovf});
        check("frame_done", {31'b0, frame_done}, {31'b0, exp_fd});
    endtask

    // One clock edge: advance the model from the inputs held across the edge,
    // then compare on the falling edge.
    task automatic step();
        beat_t b;
        bit    pop_now;
        bit    full_now;
        bit    acc;
        int    pos;
        @(posedge clk);
        pop_now  = (q.size() > 0) && (m_axis_tready == 1'b1);
        full_now = (q.size() == D);
        acc      = (s_valid == 1'b1) && (enable == 1'b1);
        exp_fd   = 1'b0;
        b        = '{data: s_data, sof: 1'b0, eol: 1'b0, eof: 1'b0};
        if (acc) begin
            pos   = idx % (W * H);
            b.sof = (pos == 0);
            b.eol = ((pos % W) == W - 1);
            b.eof = (pos == W * H - 1);
            idx++;
        end
        if (pop_now) begin
            exp_fd = q[0].eof;
            void'(q.pop_front());
        end
        if (acc) begin
            if (!full_now || pop_now) q.push_back(b);
            else exp_ovf = 1'b1;
        end
        @(negedge clk);
        compare();
    endtask

    task automatic drive(input bit v, input bit en, input bit rdy, input logic [31:0] d);
        s_valid       = v;
        enable        = en;
        m_axis_tready = rdy;
        s_data        = d;
    endtask

    function automatic logic [31:0] pix();
        return {8'h00, 24'($urandom)};
    endfunction

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        drive(0, 1, 0, '0);
        q.delete();
        idx     = 0;
        exp_ovf = 1'b0;
        exp_fd  = 1'b0;
        #2;
        check("rst_tvalid", {31'b0, m_axis_tvalid}, 32'd0);
        check("rst_tdata", m_axis_tdata, 32'd0);
        check("rst_tlast", {31'b0, m_axis_tlast}, 32'd0);
        check("rst_tuser", {31'b0, m_axis_tuser}, 32'd0);
        check("rst_overflow", {31'b0, overflow}, 32'd0);
        check("rst_frame_done", {31'b0, frame_done}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        // Full frame of 8 beats with downstream always ready
        do_reset();
        for (int i = 0; i < 8; i++) begin
            drive(1, 1, 1, 32'(i));
            step();
        end
        drive(0, 1, 1, '0);
        repeat (3) step();

        // Overfill while stalled, then drain
        do_reset();
        for (int i = 0; i < 5; i++) begin
            drive(1, 1, 0, 32'(i));
            step();
        end
        drive(0, 1, 1, '0);
        repeat (6) step();

        // Full FIFO with simultaneous pop and push
        do_reset();
        for (int i = 0; i < 4; i++) begin
            drive(1, 1, 0, pix());
            step();
        end
        drive(1, 1, 1, pix());
        step();
        drive(0, 1, 1, '0);
        repeat (6) step();

        // Alternating tready during a frame
        do_reset();
        for (int i = 0; i < 8; i++) begin
            drive(1, 1, (i % 2) == 0, pix());
            step();
        end
        for (int i = 0; i < 12; i++) begin
            drive(0, 1, (i % 2) == 1, '0);
            step();
        end

        // Enable held low mid-line with s_valid high
        do_reset();
        for (int i = 0; i < 11; i++) begin
            drive(1, !(i >= 2 && i < 5), 1, pix());
            step();
        end
        drive(0, 1, 1, '0);
        repeat (4) step();

        // Reset mid-frame, next beat must restart the frame
        do_reset();
        for (int i = 0; i < 3; i++) begin
            drive(1, 1, 0, pix());
            step();
        end
        do_reset();
        drive(1, 1, 1, pix());
        step();
        drive(0, 1, 1, '0);
        repeat (3) step();

        // Random traffic
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            drive(($urandom % 10) < 7, ($urandom % 10) < 8, ($urandom % 10) < 6, pix());
            step();
        end
        drive(0, 1, 1, '0);
        repeat (8) step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
